// File: rtl/salsa20_block_engine_if.sv
// salsa20_block_engine_if
//   Handshake bundle between a block producer/consumer and the Salsa20 engine.
//   in_valid/in_ready/in_state  : input block channel (16 x 32-bit words,
//                                 word i at bits [32i+31:32i])
//   out_valid/out_ready/out_block : result channel, same word packing
//   master : the side that supplies blocks and consumes results
//   slave  : the engine
interface salsa20_block_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/salsa20_block_engine.sv
// salsa20_block_engine
//   Iterative Salsa20 core: takes a 16-word state, applies ROUNDS rounds
//   (DR_PER_CYCLE double rounds per clock) and adds the original state back.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : salsa20_block_engine_if.slave (input and output handshakes)
//     busy : high while a block is being iterated (state RUN)
module salsa20_block_engine #(
    parameter int unsigned ROUNDS       = 20,
    parameter int unsigned DR_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    salsa20_block_engine_if.slave   bus,
    output logic                    busy
);

    localparam int unsigned N  = ROUNDS / (2 * DR_PER_CYCLE);
    localparam int unsigned CW = $clog2(N + 1);

    generate
        if (!((ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20) &&
              (DR_PER_CYCLE == 1 || DR_PER_CYCLE == 2))) begin : g_bad_params
            $error("salsa20_block_engine: unsupported ROUNDS/DR_PER_CYCLE");
        end
    endgenerate

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef logic [15:0][31:0] blk_t;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Returns {z3, z2, z1, z0}.
    function automatic logic [3:0][31:0] qr(input logic [31:0] y0, y1, y2, y3);
        logic [31:0] z0, z1, z2, z3;
        z1 = y1 ^ rotl(y0 + y3, 7);
        z2 = y2 ^ rotl(z1 + y0, 9);
        z3 = y3 ^ rotl(z2 + z1, 13);
        z0 = y0 ^ rotl(z3 + z2, 18);
        return {z3, z2, z1, z0};
    endfunction

    function automatic blk_t column_round(input blk_t x);
        blk_t             y;
        logic [3:0][31:0] q;
        y = x;
        q = qr(x[0],  x[4],  x[8],  x[12]);
        y[0]  = q[0]; y[4]  = q[1]; y[8]  = q[2]; y[12] = q[3];
        q = qr(x[5],  x[9],  x[13], x[1]);
        y[5]  = q[0]; y[9]  = q[1]; y[13] = q[2]; y[1]  = q[3];
        q = qr(x[10], x[14], x[2],  x[6]);
        y[10] = q[0]; y[14] = q[1]; y[2]  = q[2]; y[6]  = q[3];
        q = qr(x[15], x[3],  x[7],  x[11]);
        y[15] = q[0]; y[3]  = q[1]; y[7]  = q[2]; y[11] = q[3];
        return y;
    endfunction

    function automatic blk_t row_round(input blk_t x);
        blk_t             y;
        logic [3:0][31:0] q;
        y = x;
        q = qr(x[0],  x[1],  x[2],  x[3]);
        y[0]  = q[0]; y[1]  = q[1]; y[2]  = q[2]; y[3]  = q[3];
        q = qr(x[5],  x[6],  x[7],  x[4]);
        y[5]  = q[0]; y[6]  = q[1]; y[7]  = q[2]; y[4]  = q[3];
        q = qr(x[10], x[11], x[8],  x[9]);
        y[10] = q[0]; y[11] = q[1]; y[8]  = q[2]; y[9]  = q[3];
        q = qr(x[15], x[12], x[13], x[14]);
        y[15] = q[0]; y[12] = q[1]; y[13] = q[2]; y[14] = q[3];
        return y;
    endfunction

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          rdy_en;   // holds in_ready low until the first edge after reset
    blk_t          work;
    blk_t          ff;
    blk_t          out_q;
    blk_t          col_probe;   // first column round of the current working state
    blk_t          dr_out;
    blk_t          sum;
    logic          ready;
    logic          in_fire;
    logic          out_fire;

    assign col_probe = column_round(work);

    generate
        if (DR_PER_CYCLE == 2) begin : g_dr2
            assign dr_out = row_round(column_round(row_round(col_probe)));
        end else begin : g_dr1
            assign dr_out = row_round(col_probe);
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sum[i] = work[i] + ff[i];
        end
    end

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = rdy_en;
            DONE:    ready = rdy_en & bus.out_ready;
            default: ready = 1'b0;
        endcase
    end

    assign in_fire  = bus.in_valid & ready;
    assign out_fire = (state == DONE) & bus.out_ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == DONE);
    assign bus.out_block = out_q;
    assign busy          = (state == RUN);

    // RUN spends N cycles on double rounds, then one cycle adding the
    // feedforward, so out_valid rises N+1 edges after the input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rdy_en <= 1'b0;
            work   <= '0;
            ff     <= '0;
            out_q  <= '0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        work  <= bus.in_state;
                        ff    <= bus.in_state;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CW'(N)) begin
                        out_q <= sum;
                        state <= DONE;
                    end else begin
                        work <= dr_out;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_fire) begin
                        if (in_fire) begin
                            work  <= bus.in_state;
                            ff    <= bus.in_state;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_salsa20_block_engine.sv
// tb_salsa20_block_engine
//   Drives six engine instances (all ROUNDS/DR_PER_CYCLE combinations) from
//   one shared stimulus; instance 0 (20 rounds, 1 double round per cycle) is
//   used for the handshake, stall, streaming and reset scenarios.
module tb_salsa20_block_engine;

    function automatic int unsigned r_of(input int g);
        case (g)
            0, 1:    return 20;
            2, 3:    return 12;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned d_of(input int g);
        return (g % 2 == 1) ? 2 : 1;
    endfunction

    function automatic int unsigned n_of(input int g);
        return r_of(g) / (2 * d_of(g));
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] in_state;

    logic         ov [6];
    logic         ir [6];
    logic         bz [6];
    logic [511:0] ob [6];

    int unsigned  n_tests;
    int unsigned  n_fail;
    int           first_k [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int unsigned R = r_of(g);
        localparam int unsigned D = d_of(g);
        salsa20_block_engine_if u_if ();
        assign u_if.in_valid  = in_valid;
        assign u_if.in_state  = in_state;
        assign u_if.out_ready = out_ready;
        assign ov[g] = u_if.out_valid;
        assign ir[g] = u_if.in_ready;
        assign ob[g] = u_if.out_block;
        salsa20_block_engine #(.ROUNDS(R), .DR_PER_CYCLE(D)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (u_if),
            .busy (bz[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [511:0] salsa_ref(input logic [511:0] blk, input int unsigned rounds);
        logic [31:0] x [16];
        logic [31:0] j [16];
        logic [511:0] r;
        int grp [8][4] = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
                           '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}};
        for (int i = 0; i < 16; i++) begin
            x[i] = blk[32*i +: 32];
            j[i] = x[i];
        end
        for (int dr = 0; dr < int'(rounds / 2); dr++) begin
            for (int q = 0; q < 8; q++) begin
                int a, b, c, d;
                a = grp[q][0]; b = grp[q][1]; c = grp[q][2]; d = grp[q][3];
                x[b] = x[b] ^ ref_rotl(x[a] + x[d], 7);
                x[c] = x[c] ^ ref_rotl(x[b] + x[a], 9);
                x[d] = x[d] ^ ref_rotl(x[c] + x[b], 13);
                x[a] = x[a] ^ ref_rotl(x[d] + x[c], 18);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + j[i];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the block transfers on the next rising edge.
    // Returns on the falling edge right after the transfer (k = 0).
    task automatic send(input logic [511:0] b);
        in_state = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Records, per instance, the first sample k at which out_valid is seen.
    task automatic run_measure();
        for (int g = 0; g < 6; g++) first_k[g] = -1;
        for (int k = 0; k <= 20; k++) begin
            for (int g = 0; g < 6; g++)
                if (ov[g] && first_k[g] < 0) first_k[g] = k;
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [511:0] blk;
    logic [511:0] vec_c;
    logic [511:0] expv;
    logic [511:0] pr;
    logic [511:0] bb [4];
    logic [511:0] exp_q [$];
    int           tx_q [$];
    int           sent;
    int           got;
    int           ov_seen;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;

        for (int i = 0; i < 16; i++) vec_c[32*i +: 32] = 32'h03020100 + 32'h04040404 * i;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", ov[0], 0);
        check_eq("rst_in_ready", ir[0], 0);
        check_eq("rst_busy", bz[0], 0);
        check_eq("rst_out_block", ob[0], '0);
        rst = 1'b0;
        #1;
        check_eq("in_ready_before_edge", ir[0], 0);
        @(negedge clk);
        check_eq("in_ready_after_edge", ir[0], 1);

        // All-zero block: zero result, latency N+1 on every configuration
        send('0);
        for (int g = 0; g < 6; g++) begin
            check_eq($sformatf("zero_busy_%0d", g), bz[g], 1);
            check_eq($sformatf("zero_in_ready_run_%0d", g), ir[g], 0);
        end
        run_measure();
        for (int g = 0; g < 6; g++) begin
            check_eq($sformatf("zero_latency_%0d", g), first_k[g], n_of(g) + 1);
            check_eq($sformatf("zero_out_%0d", g), ob[g], '0);
        end
        release_out();
        check_eq("zero_idle_out_valid", ov[0], 0);

        // word0 = 1: first column round on the 8-round instance
        blk = '0;
        blk[31:0] = 32'h00000001;
        send(blk);
        pr = g_dut[4].u_dut.col_probe;
        check_eq("col_w0", pr[0*32 +: 32], 32'h08008145);
        check_eq("col_w4", pr[4*32 +: 32], 32'h00000080);
        check_eq("col_w8", pr[8*32 +: 32], 32'h00010200);
        check_eq("col_w12", pr[12*32 +: 32], 32'h20500000);
        run_measure();
        for (int g = 0; g < 6; g++)
            check_eq($sformatf("one_out_%0d", g), ob[g], salsa_ref(blk, r_of(g)));
        release_out();

        // Byte-sequence block on all six configurations
        send(vec_c);
        run_measure();
        for (int g = 0; g < 6; g++) begin
            check_eq($sformatf("seq_latency_%0d", g), first_k[g], n_of(g) + 1);
            check_eq($sformatf("seq_out_%0d", g), ob[g], salsa_ref(vec_c, r_of(g)));
        end
        release_out();

        // Output stall for 7 cycles
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = 32'h9e3779b9 * (i + 1);
        expv = salsa_ref(blk, 20);
        send(blk);
        run_measure();
        check_eq("stall_latency", first_k[0], 11);
        for (int c = 0; c < 7; c++) begin
            check_eq("stall_out_valid", ov[0], 1);
            check_eq("stall_out_block", ob[0], expv);
            check_eq("stall_in_ready", ir[0], 0);
            @(negedge clk);
        end
        release_out();
        check_eq("stall_released_valid", ov[0], 0);
        check_eq("stall_released_ready", ir[0], 1);
        @(negedge clk);
        check_eq("stall_idle_valid", ov[0], 0);

        // Back-to-back stream of 4 blocks on instance 0
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 16; i++)
                bb[b][32*i +: 32] = 32'h01010101 * (b + 1) + i;
        out_ready = 1'b1;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            in_valid = (sent < 4);
            if (sent < 4) in_state = bb[sent];
            if (ov[0]) begin
                got++;
                if (exp_q.size() > 0) begin
                    check_eq("b2b_data", ob[0], exp_q.pop_front());
                    check_eq("b2b_latency", cyc - tx_q.pop_front(), 12);
                end else begin
                    check_eq("b2b_extra_output", ov[0], 0);
                end
            end
            if (ir[0] && sent < 4) begin
                exp_q.push_back(salsa_ref(bb[sent], 20));
                tx_q.push_back(cyc);
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("b2b_count", got, 4);
        check_eq("b2b_sent", sent, 4);
        @(negedge clk);
        check_eq("b2b_drained", ov[0], 0);
        out_ready = 1'b0;

        // Reset during RUN cycle 3
        send(vec_c);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", ov[0], 0);
        check_eq("arst_out_block", ob[0], '0);
        check_eq("arst_busy", bz[0], 0);
        check_eq("arst_in_ready", ir[0], 0);
        check_eq("arst_work", g_dut[0].u_dut.work, '0);
        check_eq("arst_ff", g_dut[0].u_dut.ff, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("arst_ready_back", ir[0], 1);
        ov_seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (ov[0]) ov_seen++;
            @(negedge clk);
        end
        check_eq("arst_no_valid", ov_seen, 0);
        send(vec_c);
        run_measure();
        check_eq("arst_next_latency", first_k[0], 11);
        check_eq("arst_next_out", ob[0], salsa_ref(vec_c, 20));
        release_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/salsa20_block_engine.md
SALSA20_BLOCK_ENGINE -- requirements
Module: salsa20_block_engine

Interface
REQ-001 Parameter ROUNDS, default 20, meaning total Salsa20 rounds; legal values 8, 12, 20.
REQ-002 Parameter DR_PER_CYCLE, default 1, meaning double rounds computed combinationally per clock; legal values 1, 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_state holds a valid 16-word block.
REQ-006 in_ready  output  1  engine accepts a block this cycle.
REQ-007 in_state  input  512  16 x 32-bit words; word i occupies bits [32i+31:32i].
REQ-008 out_valid  output  1  out_block holds a finished block.
REQ-009 out_ready  input  1  consumer accepts out_block this cycle.
REQ-010 out_block  output  512  Salsa20 core result, same word packing as in_state.
REQ-011 busy  output  1  high while the engine is in state RUN.

Function
REQ-012 An illegal ROUNDS or DR_PER_CYCLE value shall fail elaboration.
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 A transfer on each port shall occur only on a cycle where valid and ready are both high.
REQ-015 in_ready shall be 1 in IDLE, equal to out_ready in DONE, and 0 in RUN.
REQ-016 IDLE to RUN on input transfer: latch in_state into the working register and the feedforward register, and clear the iteration counter to 0.
REQ-017 Each RUN cycle shall apply DR_PER_CYCLE double rounds to the working register and increment the counter.
REQ-018 A double round is a column round then a row round; quarterround rotations are 7, 9, 13, 18; all additions are modulo 2^32.
REQ-019 Column quarterround word groups (y0,y1,y2,y3): (0,4,8,12), (5,9,13,1), (10,14,2,6), (15,3,7,11).
REQ-020 Row quarterround word groups: (0,1,2,3), (5,6,7,4), (10,11,8,9), (15,12,13,14).
REQ-021 Let N = ROUNDS/(2*DR_PER_CYCLE). After the N-th RUN cycle the engine goes to DONE, with out_block = working word i + feedforward word i (mod 2^32) for every i.
REQ-022 Latency: out_valid rises exactly N+1 cycles after the input-transfer edge.
REQ-023 In DONE, out_valid = 1, and out_block shall stay stable until the output transfer.
REQ-024 DONE with output transfer and no input transfer: go to IDLE, with out_valid = 0 on the next cycle.
REQ-025 DONE with output and input transfers on the same cycle: latch the new block and go to RUN; no bubble cycle.
REQ-026 in_valid in RUN shall be ignored; in_state may change freely while in_ready = 0.
REQ-027 out_ready while out_valid = 0 shall have no effect.
REQ-028 The counter shall be wide enough for N and shall never wrap during RUN.

Reset
REQ-029 While rst = 1 (asynchronous assertion): state IDLE, counter 0, working, feedforward and out_block registers 0, out_valid = 0, busy = 0, in_ready = 0.
REQ-030 in_ready shall go to 1 on the first clock edge after rst deasserts.
REQ-031 Reset asserted in RUN or DONE shall discard the block in flight; no out_valid pulse shall follow.

Verification
REQ-032 All-zero in_state, ROUNDS=20, DR_PER_CYCLE=1 -> out_block all zero; out_valid rises 11 cycles after the transfer.
REQ-033 in_state word0 = 0x00000001, others 0, ROUNDS=8, DR_PER_CYCLE=1, one RUN cycle forced by probe -> after the first column round, words 0, 4, 8, 12 = 0x08008145, 0x00000080, 0x00010200, 0x20500000.
REQ-034 Words i = 0x03020100 + 0x04040404*i, all six ROUNDS/DR_PER_CYCLE combinations -> out_block matches the software reference model; N = 10, 5, 6, 3, 4, 2.
REQ-035 out_ready held 0 for 7 cycles in DONE -> out_valid stays 1, out_block stable, in_ready 0; release -> one output transfer, then IDLE.
REQ-036 Back-to-back stream of 4 blocks with in_valid and out_ready constantly 1 -> outputs every N+1 cycles, in order, none lost or duplicated.
REQ-037 rst pulsed at RUN cycle 3 of 10 -> all outputs 0 immediately, no out_valid afterwards, and the next block processes correctly.
